// File: rtl/letter_scan_pkg.sv
// Shared types and constants for the letter scan controller.
package letter_scan_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } scan_state_t;

  localparam int NUL_CHAR = 0;

endpackage

// File: rtl/letter_scan_ctrl_sat_counter.sv
// Saturating match counter with a sticky overflow flag.
// Clear wins over increment; an increment at the maximum only raises overflow.
module sat_counter
  import letter_scan_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Counter value and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value    <= {CNT_W{1'b0}};
      overflow <= 1'b0;
    end else if (clear) begin
      value    <= {CNT_W{1'b0}};
      overflow <= 1'b0;
    end else if (inc) begin
      if (value == CNT_MAX) begin
        overflow <= 1'b1;
      end else begin
        value <= value + CNT_ONE;
      end
    end else begin
      value    <= value;
      overflow <= overflow;
    end
  end

endmodule

// File: rtl/letter_scan_ctrl.sv
// Sequences one ROM scan: reads words one at a time, compares each against a
// latched letter and counts matches, with a start/busy/done handshake.
module letter_scan_ctrl
  import letter_scan_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int CNT_W       = 8,
  parameter int STOP_ON_NUL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] letter,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_q
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] NUL_WORD  = DATA_W'(NUL_CHAR);

  scan_state_t       state_r;
  scan_state_t       state_nxt_s;
  logic [DATA_W-1:0] letter_r;
  logic [DATA_W-1:0] letter_nxt_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic              rd_nxt_s;
  logic              busy_nxt_s;
  logic              done_nxt_s;
  logic              cnt_clr_s;
  logic              cnt_inc_s;

  // State register plus registered handshake and ROM interface outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      letter_r <= {DATA_W{1'b0}};
      rom_addr <= {ADDR_W{1'b0}};
      rom_rd   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      letter_r <= letter_nxt_s;
      rom_addr <= addr_nxt_s;
      rom_rd   <= rd_nxt_s;
      busy     <= busy_nxt_s;
      done     <= done_nxt_s;
    end
  end

  // Next-state and next-output decode; done lands one cycle after DONE
  always_comb begin
    state_nxt_s  = state_r;
    letter_nxt_s = letter_r;
    addr_nxt_s   = rom_addr;
    rd_nxt_s     = 1'b0;
    done_nxt_s   = 1'b0;
    cnt_clr_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    case (state_r)
      IDLE: begin
        // busy still high here means the done pulse is showing: ignore start
        if (start && !busy) begin
          letter_nxt_s = letter;
          cnt_clr_s    = 1'b1;
          addr_nxt_s   = {ADDR_W{1'b0}};
          if (letter == NUL_WORD) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = ISSUE;
            rd_nxt_s    = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        state_nxt_s = CHECK;
      end
      CHECK: begin
        if ((STOP_ON_NUL != 0) && (rom_q == NUL_WORD)) begin
          state_nxt_s = DONE;
        end else begin
          cnt_inc_s = (rom_q == letter_r);
          if (rom_addr == LAST_ADDR) begin
            state_nxt_s = DONE;
          end else begin
            addr_nxt_s  = rom_addr + ADDR_ONE;
            rd_nxt_s    = 1'b1;
            state_nxt_s = ISSUE;
          end
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        done_nxt_s  = 1'b1;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE) || (state_r == DONE);
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_count (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clr_s),
    .inc      (cnt_inc_s),
    .value    (count),
    .overflow (overflow)
  );

endmodule

// File: doc/letter_scan_ctrl.md
Name: letter_scan_ctrl

Overview:
- Controller that sequences one ROM-scan/compare pass: on a start request it walks the character ROM address by address, compares each word against a latched target letter, and counts matches.
- Sits between the top-level FSM/UI logic (requester) and the synchronous character ROM.
- Replaces free-running address counting with a start/busy/done handshake, a defined scan length, NUL termination and a saturating count.

Parameters:
- DATA_W, 8, width of ROM word and letter.
- ADDR_W, 8, ROM address width.
- DEPTH, 256, number of ROM words scanned at most; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- CNT_W, 8, match counter width.
- STOP_ON_NUL, 1, when 1 a ROM word equal to 0 ends the scan.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  scan request; sampled only in IDLE.
- letter  in  DATA_W  target character; latched when start is accepted.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle pulse when the result is valid.
- count  out  CNT_W  match count; valid from done, held until next accepted start.
- overflow  out  1  sticky: count saturated during this scan.
- rom_addr  out  ADDR_W  ROM read address.
- rom_rd  out  1  ROM read strobe (address valid).
- rom_q  in  DATA_W  ROM data, valid exactly one cycle after rom_rd.

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, count=0, overflow=0, rom_addr=0, rom_rd=0, latched letter=0. Reset mid-scan aborts immediately; no done is produced.
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE, start=1: latch letter, clear count/overflow, address=0.
  - Latched letter==0 -> DONE (count=0, no ROM access).
  - Otherwise -> ISSUE.
- ISSUE: rom_addr=address, rom_rd=1 for this cycle -> WAIT.
- WAIT: rom_rd=0, rom_addr held -> CHECK.
- CHECK: evaluate rom_q.
  - If STOP_ON_NUL and rom_q==0: no count change -> DONE.
  - Else, if rom_q==letter: count+1, saturating at 2**CNT_W-1. A match while count is already at max sets overflow; count stays at max.
  - If address==DEPTH-1 -> DONE; else address+1 -> ISSUE.
- DONE: done=1 for exactly one cycle, busy=1 -> IDLE.
- Timing: 3 cycles per word scanned. A start accepted at edge E with k words checked gives done high in the cycle after edge E+3k+1. Letter==0 gives done in the cycle after edge E+1.
- start while busy, or in the DONE cycle: ignored, not queued. start held high in IDLE after DONE starts a new scan.
- letter changes while busy have no effect.
- Address never wraps: DEPTH-1 is the last word read.
- count, overflow and rom_addr hold their values in IDLE.

Decomposition:
- Shared package letter_scan_pkg:
  - state enum type scan_state_t (IDLE, ISSUE, WAIT, CHECK, DONE).
  - constant NUL_CHAR = 0.
- One natural sub-module: sat_counter (CNT_W-wide, clear/inc inputs, saturating value, sticky overflow).
- ROM remains external; the bench uses a behavioural 1-cycle-latency ROM model.

Test Plan:
- ROM = "HELLO",0x00,...; start with letter 0x4C ('L') -> 6 words read (addr 0..5), count=2, overflow=0, done pulse 19 cycles after the accepting edge; busy=1 throughout.
- Same ROM, letter 0x5A ('Z') -> count=0, done after 6 words; rom_addr never exceeds 5.
- letter=0x00 -> no rom_rd pulses, count=0, done in the cycle after edge E+1.
- STOP_ON_NUL=0, DEPTH=4, CNT_W=2, ROM = 0x41 x4, letter 0x41 -> count=3, overflow=1, last rom_addr=3, no wrap to 0.
- Assert rst during the WAIT of word 2 -> busy, done, count, rom_rd and rom_addr all 0 immediately; no done pulse; a new start runs a clean full scan.
- Pulse start mid-scan with a different letter -> ignored; result matches the first letter; start held through DONE begins a second scan with freshly cleared count.
